text_seq_ctrl: RTL

Sequencer for the text transmit path: on a press of the start pushbutton it walks the character ROM from address 0, fetches each byte with the ROM's read latency accounted for, and presents it to the downstream modulator/serializer over a valid/ready handshake. It stops at the NUL terminator or at the end of the ROM, then reports done. It sits between the board keys and the ROM on one side, and the transmit datapath on the other, inside the text top level.

---
 rtl/text_seq_pkg.sv | 16 +
 rtl/key_edge_sync.sv | 37 +++
 rtl/text_seq_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/text_seq_pkg.sv
// text_seq_pkg: shared types and constants for the text transmit sequencer.
//   state_e       FSM state encoding (IDLE, FETCH, WAIT, PRESENT, FINISH)
//   SYNC_BYTE     framing byte sent around each message when TEXT_SEQ_SYNC_EN is defined
//   TERM_BYTE_DEF default end-of-text marker
package text_seq_pkg;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE     = 8'h7E;
  localparam logic [7:0] TERM_BYTE_DEF = 8'h00;
endpackage

// File: rtl/key_edge_sync.sv
// key_edge_sync: brings the asynchronous active-low start key into the clk
// domain and emits a one-cycle pulse on its falling edge.
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   key_n in   raw pushbutton, active-low
//   start out  one-cycle pulse, high in the cycle after the second sync flop sees 0
// All three flops reset to 1 (key released) so releasing reset never fires start.
module key_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic start
);
  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = key_n;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // s3 is the previous value of the synchronized key: 1 -> 0 is a press.
  assign start = s3_q & ~s2_q;
endmodule

// File: rtl/text_seq_ctrl.sv
// text_seq_ctrl: walks the character ROM from address 0 on a key press and
// hands each byte to the transmit datapath over valid/ready, stopping at the
// terminator byte or the last ROM address, then pulses done.
//   clk, reset        clock, asynchronous active-high reset
//   key_n             start pushbutton (active-low, asynchronous)
//   rom_addr / rom_q  character ROM read port (rom_q valid ROM_LAT cycles after addr)
//   data_out / valid  character offered downstream, accepted when ready=1
//   busy              message in progress (start+1 through the FINISH cycle)
//   done              one-cycle pulse in the FINISH cycle
// Build option: define TEXT_SEQ_SYNC_EN to frame every message with SYNC_BYTE
// before the first and after the last character (empty message = two SYNC_BYTEs).
module text_seq_ctrl
  import text_seq_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          ROM_LAT   = 2,
  parameter logic [7:0]  TERM_BYTE = TERM_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_q,
  output logic [7:0]        data_out,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              done
);
`ifdef TEXT_SEQ_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  // WAIT lasts ROM_LAT cycles: counter loads ROM_LAT-1 and samples at zero.
  localparam logic [1:0] LAT_M1 = 2'(ROM_LAT - 1);

  logic start;

  key_edge_sync u_key (
    .clk   (clk),
    .rst   (reset),
    .key_n (key_n),
    .start (start)
  );

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        cnt_q, cnt_d;
  // sync_pend: next FETCH presents SYNC_BYTE instead of reading the ROM.
  // sync_tail: the pending/current sync byte closes the message.
  // sync_cur : the byte in PRESENT is a sync byte, not a ROM character.
  logic              sync_pend_q, sync_pend_d;
  logic              sync_tail_q, sync_tail_d;
  logic              sync_cur_q, sync_cur_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    sync_pend_d = sync_pend_q;
    sync_tail_d = sync_tail_q;
    sync_cur_d  = sync_cur_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = '0;
          busy_d      = 1'b1;
          sync_pend_d = SYNC_EN;
          sync_tail_d = 1'b0;
          state_d     = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (sync_pend_q) begin
          data_d      = SYNC_BYTE;
          valid_d     = 1'b1;
          sync_pend_d = 1'b0;
          sync_cur_d  = 1'b1;
          state_d     = ST_PRESENT;
        end else begin
          cnt_d   = LAT_M1;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else if (rom_q == TERM_BYTE) begin
          if (SYNC_EN) begin
            sync_pend_d = 1'b1;
            sync_tail_d = 1'b1;
            state_d     = ST_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end
        end else begin
          data_d     = rom_q;
          valid_d    = 1'b1;
          sync_cur_d = 1'b0;
          state_d    = ST_PRESENT;
        end
      end

      ST_PRESENT: begin
        if (ready) begin
          valid_d = 1'b0;
          if (sync_cur_q) begin
            sync_cur_d = 1'b0;
            if (sync_tail_q) begin
              done_d  = 1'b1;
              state_d = ST_FINISH;
            end else begin
              state_d = ST_FETCH;
            end
          end else if (addr_q == '1) begin
            // End of ROM: never increment past the last address.
            if (SYNC_EN) begin
              sync_pend_d = 1'b1;
              sync_tail_d = 1'b1;
              state_d     = ST_FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = ST_FINISH;
            end
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end

      ST_FINISH: begin
        busy_d      = 1'b0;
        addr_d      = '0;
        sync_tail_d = 1'b0;
        state_d     = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= 2'd0;
      sync_pend_q <= 1'b0;
      sync_tail_q <= 1'b0;
      sync_cur_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      sync_pend_q <= sync_pend_d;
      sync_tail_q <= sync_tail_d;
      sync_cur_q  <= sync_cur_d;
    end
  end

  assign rom_addr = addr_q;
  assign data_out = data_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule
